// File: rtl/spi_slave.sv
// spi_slave: SPI target that oversamples the pad-side SPI pins in the system clock domain, MSB first.
// Define SPI_SLAVE_MODE_EN to add a {CPOL, CPHA} mode port; otherwise the block is fixed to mode 0.
module spi_slave #(
    parameter int           W    = 8,
    parameter logic [W-1:0] FILL = {W{1'b1}}
) (
    input  logic         clock,
    input  logic         reset,
`ifdef SPI_SLAVE_MODE_EN
    input  logic [1:0]   mode,
`endif
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    output logic         underrun,
    input  logic         spi_cs_n,
    input  logic         spi_clock,
    input  logic         spi_mosi,
    output logic         spi_miso
);
    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          cs_meta_reg, cs_sync_reg, cs_prev_reg;
    logic          sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
    logic          mosi_meta_reg, mosi_sync_reg;
    logic [W-1:0]  tx_reg;
    logic [W-1:0]  rx_reg;
    logic [CW-1:0] cnt_reg;

    logic          cpol, cpha;
    logic          sclk_now, sclk_was;
    logic          lead_edge, trail_edge, sample_edge, shift_edge;
    logic          cs_fall;
    logic [W-1:0]  rx_next;
    logic [W-1:0]  load_word;

    // Two-flop synchronisers; cs_n and sclk get a third flop for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_meta_reg   <= 1'b1;
            cs_sync_reg   <= 1'b1;
            cs_prev_reg   <= 1'b1;
            sclk_meta_reg <= 1'b0;
            sclk_sync_reg <= 1'b0;
            sclk_prev_reg <= 1'b0;
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
        end else begin
            cs_meta_reg   <= spi_cs_n;
            cs_sync_reg   <= cs_meta_reg;
            cs_prev_reg   <= cs_sync_reg;
            sclk_meta_reg <= spi_clock;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_prev_reg <= sclk_sync_reg;
            mosi_meta_reg <= spi_mosi;
            mosi_sync_reg <= mosi_meta_reg;
        end
    end

`ifdef SPI_SLAVE_MODE_EN
    logic [1:0] mode_reg;

    // Mode is frozen for the whole selected period so a mid-transfer change cannot glitch edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_reg <= 2'b00;
        end else if (cs_sync_reg) begin
            mode_reg <= mode;
        end
    end

    assign cpol = mode_reg[1];
    assign cpha = mode_reg[0];
`else
    assign cpol = 1'b0;
    assign cpha = 1'b0;
`endif

    assign sclk_now    = sclk_sync_reg ^ cpol;
    assign sclk_was    = sclk_prev_reg ^ cpol;
    assign lead_edge   = sclk_now & ~sclk_was;
    assign trail_edge  = ~sclk_now & sclk_was;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_reg & ~cs_sync_reg;
    assign rx_next     = {rx_reg[W-2:0], mosi_sync_reg};
    assign load_word   = empty ? FILL : in;

    // tx_reg is cleared while deselected, which both idles MISO low and drops any prefetched word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_reg   <= '0;
            rx_reg   <= '0;
            cnt_reg  <= '0;
            out      <= '0;
            get      <= 1'b0;
            put      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            get      <= 1'b0;
            put      <= 1'b0;
            underrun <= 1'b0;
            if (cs_sync_reg) begin
                tx_reg  <= '0;
                rx_reg  <= '0;
                cnt_reg <= '0;
            end else if (cs_fall) begin
                tx_reg   <= load_word;
                get      <= ~empty;
                underrun <= empty;
            end else if (sample_edge) begin
                rx_reg <= rx_next;
                if (cnt_reg == LAST) begin
                    cnt_reg  <= '0;
                    out      <= rx_next;
                    put      <= 1'b1;
                    tx_reg   <= load_word;
                    get      <= ~empty;
                    underrun <= empty;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else if (shift_edge && (cnt_reg != '0)) begin
                // At count 0 the freshly loaded MSB must stay on the wire for the next sample.
                tx_reg <= {tx_reg[W-2:0], 1'b0};
            end
        end
    end

    assign spi_miso = tx_reg[W-1];

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table-driven single-byte transfers plus hand-written back-to-back, abort,
// async-reset and (with SPI_SLAVE_MODE_EN) mode-freeze sequences for spi_slave.
module tb_spi_slave;
    logic       clk;
    logic       rst_n;
    logic       spi_cs_n, spi_clock, spi_mosi;
    logic       spi_miso;
    logic       get, put, underrun;
    logic [7:0] dut_out;
    logic [7:0] src_in;
    logic       src_empty;
`ifdef SPI_SLAVE_MODE_EN
    logic [1:0] mode;
`endif

    // Simple word source: main process appends, pop happens on each get pulse.
    logic [7:0] src_words [64];
    int         src_count;
    int         src_idx;

    int         get_total, put_total, und_total;
    logic [7:0] put_log [64];
    time        put_time;
    time        last_edge;

    int         checks;
    int         passed;
    logic       cur_cpol, cur_cpha;

    spi_slave #(.W(8), .FILL(8'hFF)) dut (
        .clock     (clk),
        .reset     (rst_n),
`ifdef SPI_SLAVE_MODE_EN
        .mode      (mode),
`endif
        .in        (src_in),
        .get       (get),
        .empty     (src_empty),
        .out       (dut_out),
        .put       (put),
        .underrun  (underrun),
        .spi_cs_n  (spi_cs_n),
        .spi_clock (spi_clock),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign src_empty = (src_idx >= src_count);
    assign src_in    = src_words[src_idx[5:0]];

    initial src_idx = 0;
    always @(posedge clk) begin
        if (get) src_idx <= src_idx + 1;
    end

    initial begin
        get_total = 0;
        put_total = 0;
        und_total = 0;
        put_time  = 0;
    end
    always @(negedge clk) begin
        if (get) get_total++;
        if (underrun) und_total++;
        if (put) begin
            if (put_total < 64) put_log[put_total] = dut_out;
            put_time = $time;
            put_total++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic load_src(input int n, input logic [7:0] a, input logic [7:0] b);
        if (n > 0) begin src_words[src_count] = a; src_count++; end
        if (n > 1) begin src_words[src_count] = b; src_count++; end
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cur_cpol  = pol;
        cur_cpha  = pha;
        spi_clock = pol;
`ifdef SPI_SLAVE_MODE_EN
        mode = {pol, pha};
`endif
        #100;
    endtask

    task automatic select_cs();
        spi_cs_n = 1'b0;
        #50;
    endtask

    task automatic deselect_cs();
        #50;
        spi_cs_n = 1'b1;
        #100;
    endtask

    // Master bit engine: MSB first, samples MISO on the edge the slave does not shift on.
    task automatic spi_xfer(input logic [7:0] b, input int nbits, output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cur_cpha) begin
                spi_mosi  = b[i];
                #50;
                spi_clock = ~cur_cpol;
                m[i]      = spi_miso;
                last_edge = $time;
                #50;
                spi_clock = cur_cpol;
            end else begin
                spi_clock = ~cur_cpol;
                spi_mosi  = b[i];
                #50;
                spi_clock = cur_cpol;
                m[i]      = spi_miso;
                last_edge = $time;
                #50;
            end
        end
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] w0;
        logic [7:0] w1;
        int         nwords;
        logic       cpol;
        logic       cpha;
        logic [7:0] exp_out;
        logic [7:0] exp_miso;
        int         exp_get;
        int         exp_und;
    } vec_t;

    vec_t vecs [8];
    int   n_vec;

    initial begin
        logic [7:0] m;
        int g0, p0, u0;

        checks    = 0;
        passed    = 0;
        src_count = 0;
        cur_cpol  = 1'b0;
        cur_cpha  = 1'b0;
        last_edge = 0;

        // The word fetched at the final wrap is consumed even though it never goes out.
        n_vec = 0;
        vecs[n_vec++] = '{8'hA5, 8'h3C, 8'h00, 2, 1'b0, 1'b0, 8'hA5, 8'h3C, 2, 0};
        vecs[n_vec++] = '{8'h5A, 8'h00, 8'h00, 0, 1'b0, 1'b0, 8'h5A, 8'hFF, 0, 2};
        vecs[n_vec++] = '{8'h00, 8'h81, 8'h00, 1, 1'b0, 1'b0, 8'h00, 8'h81, 1, 1};
        vecs[n_vec++] = '{8'hFF, 8'h00, 8'h55, 2, 1'b0, 1'b0, 8'hFF, 8'h00, 2, 0};
`ifdef SPI_SLAVE_MODE_EN
        vecs[n_vec++] = '{8'h96, 8'h69, 8'h00, 2, 1'b0, 1'b1, 8'h96, 8'h69, 2, 0};
        vecs[n_vec++] = '{8'h96, 8'h69, 8'h00, 2, 1'b1, 1'b0, 8'h96, 8'h69, 2, 0};
        vecs[n_vec++] = '{8'h96, 8'h69, 8'h00, 2, 1'b1, 1'b1, 8'h96, 8'h69, 2, 0};
        mode = 2'b00;
`endif

        rst_n     = 1'b0;
        spi_cs_n  = 1'b1;
        spi_clock = 1'b0;
        spi_mosi  = 1'b0;
        #1;
        check("reset_outputs", {23'd0, get, put, underrun, spi_miso, dut_out},
              32'd0);
        #30;
        rst_n = 1'b1;
        @(negedge clk);
        #100;

        for (int v = 0; v < n_vec; v++) begin
            set_mode(vecs[v].cpol, vecs[v].cpha);
            load_src(vecs[v].nwords, vecs[v].w0, vecs[v].w1);
            g0 = get_total; p0 = put_total; u0 = und_total;
            select_cs();
            check($sformatf("v%0d_get_at_select", v), get_total - g0, (vecs[v].nwords > 0) ? 1 : 0);
            spi_xfer(vecs[v].mosi, 8, m);
            if (v == 0) check("v0_put_latency_ns", 32'(put_time - last_edge), 30);
            deselect_cs();
            check($sformatf("v%0d_out", v), dut_out, vecs[v].exp_out);
            check($sformatf("v%0d_miso", v), m, vecs[v].exp_miso);
            check($sformatf("v%0d_puts", v), put_total - p0, 1);
            check($sformatf("v%0d_gets", v), get_total - g0, vecs[v].exp_get);
            check($sformatf("v%0d_underruns", v), und_total - u0, vecs[v].exp_und);
            $display("vector %0d: mode %0d%0d mosi 0x%02h -> out 0x%02h miso 0x%02h", v,
                     vecs[v].cpol, vecs[v].cpha, vecs[v].mosi, dut_out, m);
        end

        // Back-to-back: three bytes under one select.
        set_mode(1'b0, 1'b0);
        src_words[src_count] = 8'h11; src_count++;
        src_words[src_count] = 8'h22; src_count++;
        load_src(2, 8'h33, 8'h44);
        g0 = get_total; p0 = put_total; u0 = und_total;
        select_cs();
        spi_xfer(8'h01, 8, m); check("b2b_miso0", m, 8'h11);
        spi_xfer(8'h80, 8, m); check("b2b_miso1", m, 8'h22);
        spi_xfer(8'hFF, 8, m); check("b2b_miso2", m, 8'h33);
        deselect_cs();
        check("b2b_puts", put_total - p0, 3);
        check("b2b_put0", put_log[p0[5:0]], 8'h01);
        check("b2b_put1", put_log[p0[5:0] + 6'd1], 8'h80);
        check("b2b_put2", put_log[p0[5:0] + 6'd2], 8'hFF);
        check("b2b_gets", get_total - g0, 4);
        check("b2b_underruns", und_total - u0, 0);
        $display("back-to-back: puts %0d gets %0d", put_total - p0, get_total - g0);

        // Abort after 5 bits: no put, out unchanged, fetched word dropped.
        load_src(1, 8'h3C, 8'h00);
        g0 = get_total; p0 = put_total;
        select_cs();
        spi_xfer(8'hC3, 5, m);
        deselect_cs();
        check("abort_puts", put_total - p0, 0);
        check("abort_out_held", dut_out, 8'hFF);
        check("abort_gets", get_total - g0, 1);
        load_src(2, 8'h24, 8'h00);
        p0 = put_total;
        select_cs();
        spi_xfer(8'h7E, 8, m);
        deselect_cs();
        check("after_abort_out", dut_out, 8'h7E);
        check("after_abort_miso", m, 8'h24);
        check("after_abort_puts", put_total - p0, 1);
        $display("abort: out 0x%02h, next miso 0x%02h", dut_out, m);

        // Async reset mid-byte.
        load_src(1, 8'hFF, 8'h00);
        select_cs();
        spi_xfer(8'h00, 4, m);
        check("pre_reset_miso", spi_miso, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {23'd0, get, put, underrun, spi_miso, dut_out}, 32'd0);
        spi_cs_n = 1'b1;
        @(negedge clk);
        #50;
        rst_n = 1'b1;
        #100;
        load_src(2, 8'hA1, 8'h00);
        p0 = put_total;
        select_cs();
        spi_xfer(8'h3E, 8, m);
        deselect_cs();
        check("post_reset_out", dut_out, 8'h3E);
        check("post_reset_miso", m, 8'hA1);
        check("post_reset_puts", put_total - p0, 1);
        $display("reset: post-reset out 0x%02h miso 0x%02h", dut_out, m);

`ifdef SPI_SLAVE_MODE_EN
        // Mode change while selected must wait for the next deselect.
        set_mode(1'b0, 1'b0);
        load_src(2, 8'h69, 8'h00);
        select_cs();
        mode = 2'b11;
        spi_xfer(8'h96, 8, m);
        deselect_cs();
        check("mode_frozen_out", dut_out, 8'h96);
        check("mode_frozen_miso", m, 8'h69);
        set_mode(1'b1, 1'b1);
        load_src(2, 8'h69, 8'h00);
        select_cs();
        spi_xfer(8'hC5, 8, m);
        deselect_cs();
        check("mode_applied_out", dut_out, 8'hC5);
        check("mode_applied_miso", m, 8'h69);
        $display("mode freeze: out 0x%02h miso 0x%02h", dut_out, m);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
